// File: rtl/el2_exu_gf2m_mul.sv
// ---------------------------------------------------------------------------
// el2_exu_gf2m_mul
// Bit-serial GF(2^M) polynomial-basis multiplier. On a request it captures
// the operands and the reduction polynomial, then computes a*b mod f(x),
// where f(x) = x^M + poly, MSB-first with one iteration per clock. The
// product is held stable until the requester releases enable_i.
//
// Ports
//   clk        : clock
//   rst_l      : asynchronous active-low reset
//   a_i, b_i   : operands (M bits), sampled when a multiply starts
//   poly_i     : reduction polynomial without the x^M term, sampled at start
//   enable_i   : level request; high starts/holds, low releases or aborts
//   result_o   : registered product
//   finish_o   : high while the product is being held (DONE)
//   finish_p_o : one-cycle pulse on entry to DONE
//   busy_o     : high while iterating (RUN)
// ---------------------------------------------------------------------------
module el2_exu_gf2m_mul #(
  parameter int M = 409
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  input  logic [M-1:0] poly_i,
  input  logic         enable_i,
  output logic [M-1:0] result_o,
  output logic         finish_o,
  output logic         finish_p_o,
  output logic         busy_o
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [M-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic [M-1:0]    p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    result_q, result_d;
  logic            finish_p_q, finish_p_d;
  logic [M-1:0]    acc_step;

  // One MSB-first iteration: multiply the accumulator by x (reducing the
  // term that falls out at x^M before anything else), then add a when the
  // current multiplier bit is set.
  function automatic logic [M-1:0] gf_step(input logic [M-1:0] acc,
                                           input logic [M-1:0] a,
                                           input logic [M-1:0] p,
                                           input logic         bbit);
    logic [M-1:0] sh;
    sh = {acc[M-2:0], 1'b0} ^ ({M{acc[M-1]}} & p);
    return sh ^ ({M{bbit}} & a);
  endfunction

  assign acc_step = gf_step(acc_q, a_q, p_q, b_q[M-1]);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    finish_p_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RUN;
          a_d     = a_i;
          b_d     = b_i;
          p_d     = poly_i;
          acc_d   = '0;
          cnt_d   = CW'(M - 1);
        end
      end
      RUN: begin
        // Dropping the request abandons the multiply without touching the
        // previously delivered result.
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          b_d   = {b_q[M-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d    = DONE;
            result_d   = acc_step;
            finish_p_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State/datapath register stage
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      finish_p_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      finish_p_q <= finish_p_d;
    end
  end

  assign result_o   = result_q;
  assign finish_o   = (state_q == DONE);
  assign finish_p_o = finish_p_q;
  assign busy_o     = (state_q == RUN);

endmodule

// File: tb/tb_el2_exu_gf2m_mul.sv
module tb_el2_exu_gf2m_mul;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   a8, b8, p8, r8;
  logic         en8, fin8, fp8, busy8;
  logic [408:0] a409, b409, p409, r409;
  logic         en409, fin409, fp409, busy409;

  el2_exu_gf2m_mul #(.M(8)) u_dut8 (
    .clk(clk), .rst_l(rst_l), .a_i(a8), .b_i(b8), .poly_i(p8),
    .enable_i(en8), .result_o(r8), .finish_o(fin8),
    .finish_p_o(fp8), .busy_o(busy8)
  );

  el2_exu_gf2m_mul #(.M(409)) u_dut409 (
    .clk(clk), .rst_l(rst_l), .a_i(a409), .b_i(b409), .poly_i(p409),
    .enable_i(en409), .result_o(r409), .finish_o(fin409),
    .finish_p_o(fp409), .busy_o(busy409)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [408:0] obs, input logic [408:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full carry-less product, then polynomial long division by
  // f(x) = x^m + p from the top degree down.
  function automatic logic [408:0] gf_ref(input logic [408:0] a, input logic [408:0] b,
                                          input logic [408:0] p, input int m);
    logic [817:0] prod, f;
    logic [408:0] r;
    prod = '0;
    for (int i = 0; i < m; i++) if (b[i]) prod ^= ({409'b0, a} << i);
    f = '0;
    for (int i = 0; i < m; i++) f[i] = p[i];
    f[m] = 1'b1;
    for (int k = 2 * m - 2; k >= m; k--) if (prod[k]) prod ^= (f << (k - m));
    r = '0;
    for (int i = 0; i < m; i++) r[i] = prod[i];
    return r;
  endfunction

  function automatic logic [408:0] rand409();
    logic [408:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) r = (r << 32) | 409'($urandom());
    return r;
  endfunction

  // Starts an M=8 multiply (this cycle is the request cycle) and waits for
  // completion, checking latency, result and single-pulse behaviour.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                      input string tag);
    logic [408:0] exp;
    int n;
    bit got;
    exp = gf_ref(409'(a), 409'(b), 409'(p), 8);
    a8 = a; b8 = b; p8 = p; en8 = 1'b1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      tick();
      n++;
      if (n == 1) chk({tag, "_busy"}, 409'(busy8), 409'(1));
      if (fp8) got = 1;
    end
    chk({tag, "_lat"}, 409'(n), 409'(9));
    chk({tag, "_res"}, 409'(r8), exp);
    chk({tag, "_fin"}, 409'(fin8), 409'(1));
    chk({tag, "_busy_lo"}, 409'(busy8), 409'(0));
    tick();
    chk({tag, "_pulse1"}, 409'(fp8), 409'(0));
    chk({tag, "_fin_hold"}, 409'(fin8), 409'(1));
  endtask

  task automatic run409(input logic [408:0] a, input logic [408:0] b, input logic [408:0] p,
                        input logic [408:0] exp, input bit toggle, input string tag);
    int n;
    bit got;
    a409 = a; b409 = b; p409 = p; en409 = 1'b1;
    n = 0; got = 0;
    while (!got && n < 1000) begin
      tick();
      n++;
      if (toggle) begin
        a409 = rand409(); b409 = rand409(); p409 = rand409();
      end
      if (fp409) got = 1;
    end
    chk({tag, "_lat"}, 409'(n), 409'(410));
    chk({tag, "_res"}, r409, exp);
    chk({tag, "_fin"}, 409'(fin409), 409'(1));
    en409 = 1'b0;
    tick();
    chk({tag, "_rel"}, 409'(fin409), 409'(0));
  endtask

  logic [408:0] stable, one, bits, rb;
  logic [7:0]   ra, rbb;
  int           pulses;

  initial begin
    en8 = 0; a8 = 0; b8 = 0; p8 = 0;
    en409 = 0; a409 = 0; b409 = 0; p409 = 0;

    // Reset state
    tick(); tick();
    chk("rst_res8", 409'(r8), 409'(0));
    chk("rst_fin8", 409'(fin8), 409'(0));
    chk("rst_fp8", 409'(fp8), 409'(0));
    chk("rst_busy8", 409'(busy8), 409'(0));
    chk("rst_res409", r409, 409'(0));
    chk("rst_busy409", 409'(busy409), 409'(0));
    @(negedge clk);
    rst_l = 1'b1;
    tick();

    // AES field multiply with enable held, then 20 cycles of stable hold
    run8(8'h57, 8'h83, 8'h1B, "aes");
    chk("aes_const", 409'(r8), 409'(8'hC1));
    stable = 409'(r8);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fp8) pulses++;
      chk("aes_hold_fin", 409'(fin8), 409'(1));
      chk("aes_hold_res", 409'(r8), stable);
    end
    chk("aes_hold_pulses", 409'(pulses), 409'(0));

    // Abort after 4 RUN iterations
    en8 = 1'b0;
    tick();
    chk("abort_idle_fin", 409'(fin8), 409'(0));
    a8 = 8'h57; b8 = 8'h83; en8 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fp8) pulses++;
    end
    chk("abort_busy", 409'(busy8), 409'(1));
    en8 = 1'b0;
    tick();
    if (fp8) pulses++;
    chk("abort_busy_lo", 409'(busy8), 409'(0));
    chk("abort_fin_lo", 409'(fin8), 409'(0));
    tick();
    if (fp8) pulses++;
    chk("abort_no_pulse", 409'(pulses), 409'(0));
    chk("abort_res_kept", 409'(r8), 409'(8'hC1));
    run8(8'h02, 8'h87, 8'h1B, "restart");
    chk("restart_const", 409'(r8), 409'(8'h15));

    // Back-to-back random multiplies with a single-cycle release between
    for (int k = 0; k < 4; k++) begin
      en8 = 1'b0;
      tick();
      chk("b2b_fin_lo", 409'(fin8), 409'(0));
      chk("b2b_fp_lo", 409'(fp8), 409'(0));
      ra = 8'($urandom());
      rbb = 8'($urandom());
      run8(ra, rbb, (k < 2) ? 8'h1B : 8'($urandom()), "b2b");
    end

    // M=409: reduction across x^M
    bits = '0; bits[87] = 1'b1; bits[0] = 1'b1;
    one = '0; one[408] = 1'b1;
    run409(one, 409'(2), bits, bits, 1'b0, "red");
    chk("red_model", r409, gf_ref(one, 409'(2), bits, 409));

    // Identity and zero with operands toggled during RUN
    rb = rand409();
    run409(409'(1), rb, bits, rb, 1'b1, "ident");
    run409(409'(0), rand409(), bits, 409'(0), 1'b1, "zero");
    one = rand409(); rb = rand409();
    run409(one, rb, bits, gf_ref(one, rb, bits, 409), 1'b0, "rand409");

    // Reset mid-RUN at iteration 3
    en8 = 1'b0;
    tick();
    a8 = 8'hA5; b8 = 8'h3C; p8 = 8'h1B; en8 = 1'b1;
    tick(); tick(); tick(); tick();
    chk("mrst_busy_pre", 409'(busy8), 409'(1));
    rst_l = 1'b0;
    #1;
    chk("mrst_res", 409'(r8), 409'(0));
    chk("mrst_fin", 409'(fin8), 409'(0));
    chk("mrst_fp", 409'(fp8), 409'(0));
    chk("mrst_busy", 409'(busy8), 409'(0));
    @(negedge clk);
    rst_l = 1'b1;
    run8(8'hA5, 8'h3C, 8'h1B, "mrst_full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
